// File: rtl/axis_iter_divider.sv
// Radix-2 restoring divider with independent AXI-stream operand channels and an
// unstallable one-cycle result strobe. Result is packed as {quotient, remainder}.
module axis_iter_divider #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    output logic                 m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state;
    logic             dvd_cap;
    logic             dvs_cap;
    logic [WIDTH-1:0] dvd_hold;
    logic [WIDTH-1:0] dvs_hold;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_work;
    logic             q_neg;
    logic             r_neg;
    logic             div0;
    logic [CW-1:0]    cnt;

    logic             dvd_fire;
    logic             dvs_fire;
    logic [WIDTH-1:0] cur_dvd;
    logic [WIDTH-1:0] cur_dvs;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign s_axis_dividend_tready = (state == S_IDLE) && !dvd_cap;
    assign s_axis_divisor_tready  = (state == S_IDLE) && !dvs_cap;

    // Operand selection, magnitude conversion, trial subtraction and sign fix-up.
    always_comb begin
        dvd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;
        dvs_fire = s_axis_divisor_tvalid && s_axis_divisor_tready;
        cur_dvd  = dvd_fire ? s_axis_dividend_tdata : dvd_hold;
        cur_dvs  = dvs_fire ? s_axis_divisor_tdata : dvs_hold;
        dvd_neg  = SIGNED && cur_dvd[WIDTH-1];
        dvs_neg  = SIGNED && cur_dvs[WIDTH-1];
        dvd_abs  = dvd_neg ? -cur_dvd : cur_dvd;
        dvs_abs  = dvs_neg ? -cur_dvs : cur_dvs;
        // The shifted partial remainder needs one extra bit before the compare.
        shifted  = {rem, quo[WIDTH-1]};
        ge       = shifted >= {1'b0, dvs_work};
        // Divide by zero leaves quo all ones and rem = |dividend|; only the quotient needs overriding.
        q_fix    = div0 ? '1 : (q_neg ? -quo : quo);
        r_fix    = r_neg ? -rem : rem;
    end

    // Capture FSM, iteration datapath and registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_IDLE;
            dvd_cap            <= 1'b0;
            dvs_cap            <= 1'b0;
            dvd_hold           <= '0;
            dvs_hold           <= '0;
            rem                <= '0;
            quo                <= '0;
            dvs_work           <= '0;
            q_neg              <= 1'b0;
            r_neg              <= 1'b0;
            div0               <= 1'b0;
            cnt                <= '0;
            m_axis_dout_tvalid <= 1'b0;
            m_axis_dout_tdata  <= '0;
        end else begin
            m_axis_dout_tvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dvd_fire) begin
                        dvd_cap  <= 1'b1;
                        dvd_hold <= s_axis_dividend_tdata;
                    end
                    if (dvs_fire) begin
                        dvs_cap  <= 1'b1;
                        dvs_hold <= s_axis_divisor_tdata;
                    end
                    if ((dvd_cap || dvd_fire) && (dvs_cap || dvs_fire)) begin
                        rem      <= '0;
                        quo      <= dvd_abs;
                        dvs_work <= dvs_abs;
                        q_neg    <= dvd_neg ^ dvs_neg;
                        r_neg    <= dvd_neg;
                        div0     <= (cur_dvs == '0);
                        cnt      <= '0;
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    rem <= ge ? (shifted[WIDTH-1:0] - dvs_work) : shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    m_axis_dout_tdata  <= {q_fix, r_fix};
                    m_axis_dout_tvalid <= 1'b1;
                    dvd_cap            <= 1'b0;
                    dvs_cap            <= 1'b0;
                    state              <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_iter_divider.sv
// Bench for axis_iter_divider: a signed and an unsigned instance share the same
// operand stimulus; results are compared against plain-arithmetic division.
module tb_axis_iter_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dvd_data;
    logic [31:0] dvs_data;
    logic        dvd_valid;
    logic        dvs_valid;

    logic        rdy_dvd_s, rdy_dvs_s, tv_s;
    logic [63:0] td_s;
    logic        rdy_dvd_u, rdy_dvs_u, tv_u;
    logic [63:0] td_u;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    axis_iter_divider #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (rdy_dvd_s),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (rdy_dvs_s),
        .m_axis_dout_tvalid     (tv_s),
        .m_axis_dout_tdata      (td_s)
    );

    axis_iter_divider #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (rdy_dvd_u),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (rdy_dvs_u),
        .m_axis_dout_tvalid     (tv_u),
        .m_axis_dout_tdata      (td_u)
    );

    // Reference: language division (truncating, remainder follows dividend), plus the div-by-zero rule.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint      sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned gap, input bit dvs_first, input bit noise);
        logic [63:0] exp_s, exp_u;
        int unsigned n;
        bit          rdy_leak;
        exp_s = ref_div(a, b, 1'b1);
        exp_u = ref_div(a, b, 1'b0);
        chk({tag, ":idle_rdy"}, 64'({rdy_dvd_s, rdy_dvs_s, rdy_dvd_u, rdy_dvs_u}), 64'hF);
        if (gap == 0) begin
            dvd_data = a; dvs_data = b; dvd_valid = 1'b1; dvs_valid = 1'b1;
            tick();
        end else begin
            if (dvs_first) begin dvs_data = b; dvs_valid = 1'b1; end
            else begin dvd_data = a; dvd_valid = 1'b1; end
            tick();
            for (int i = 1; i <= int'(gap); i++) begin
                // First channel keeps tvalid high with new data: must not be re-captured.
                if (dvs_first) dvs_data = $urandom; else dvd_data = $urandom;
                chk({tag, ":gap_rdy"}, 64'({rdy_dvd_s, rdy_dvs_s, rdy_dvd_u, rdy_dvs_u}),
                    dvs_first ? 64'hA : 64'h5);
                if (i == int'(gap)) begin
                    if (dvs_first) begin dvd_data = a; dvd_valid = 1'b1; end
                    else begin dvs_data = b; dvs_valid = 1'b1; end
                end
                tick();
            end
        end
        dvd_valid = 1'b0; dvs_valid = 1'b0;
        dvd_data = $urandom; dvs_data = $urandom;
        n = 0;
        rdy_leak = 1'b0;
        while (!tv_s && n < 40) begin
            if (noise && n < 20) begin
                dvd_valid = 1'b1; dvs_valid = 1'b1;
                dvd_data = $urandom; dvs_data = $urandom;
            end else begin
                dvd_valid = 1'b0; dvs_valid = 1'b0;
            end
            rdy_leak |= rdy_dvd_s | rdy_dvs_s | rdy_dvd_u | rdy_dvs_u;
            tick();
            n++;
        end
        dvd_valid = 1'b0; dvs_valid = 1'b0;
        chk({tag, ":latency"}, 64'(n), 64'd33);
        chk({tag, ":busy_rdy"}, 64'(rdy_leak), 64'd0);
        chk({tag, ":tv_u"}, 64'(tv_u), 64'd1);
        chk({tag, ":data_s"}, td_s, exp_s);
        chk({tag, ":data_u"}, td_u, exp_u);
        chk({tag, ":strobe_rdy"}, 64'({rdy_dvd_s, rdy_dvs_s, rdy_dvd_u, rdy_dvs_u}), 64'hF);
        tick();
        chk({tag, ":strobe_end"}, 64'({tv_s, tv_u}), 64'd0);
        chk({tag, ":hold_s"}, td_s, exp_s);
        chk({tag, ":hold_u"}, td_u, exp_u);
    endtask

    initial begin
        int unsigned n;
        bit          strobe_seen;
        logic [31:0] a, b;
        reset = 1'b1;
        dvd_valid = 1'b0; dvs_valid = 1'b0;
        dvd_data = '0; dvs_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_tv", 64'({tv_s, tv_u}), 64'd0);
        chk("reset_td_s", td_s, 64'd0);
        chk("reset_td_u", td_u, 64'd0);
        chk("reset_rdy", 64'({rdy_dvd_s, rdy_dvs_s, rdy_dvd_u, rdy_dvs_u}), 64'hF);

        // Directed cases.
        run_op("u100_7",   32'd100,         32'd7,          0, 1'b0, 1'b0);
        run_op("m7_2",     32'hFFFF_FFF9,   32'd2,          0, 1'b0, 1'b0);
        run_op("7_m2",     32'd7,           32'hFFFF_FFFE,  0, 1'b0, 1'b0);
        run_op("5_0",      32'd5,           32'd0,          0, 1'b0, 1'b0);
        run_op("m5_0",     32'hFFFF_FFFB,   32'd0,          0, 1'b0, 1'b0);
        run_op("min_m1",   32'h8000_0000,   32'hFFFF_FFFF,  0, 1'b0, 1'b0);
        run_op("max_1",    32'hFFFF_FFFF,   32'd1,          0, 1'b0, 1'b0);
        run_op("stagger5", 32'd123456,      32'd789,        5, 1'b0, 1'b1);
        run_op("dvs_first",32'hFFFF_0000,   32'd3,          3, 1'b1, 1'b1);

        // Reset in the middle of an operation.
        dvd_data = 32'd1000; dvs_data = 32'd7;
        dvd_valid = 1'b1; dvs_valid = 1'b1;
        tick();
        dvd_valid = 1'b0; dvs_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_tv", 64'({tv_s, tv_u}), 64'd0);
        chk("midrst_td_s", td_s, 64'd0);
        chk("midrst_td_u", td_u, 64'd0);
        chk("midrst_rdy", 64'({rdy_dvd_s, rdy_dvs_s, rdy_dvd_u, rdy_dvs_u}), 64'hF);
        strobe_seen = 1'b0;
        for (n = 0; n < 40; n++) begin
            strobe_seen |= tv_s | tv_u;
            tick();
        end
        chk("midrst_no_strobe", 64'(strobe_seen), 64'd0);
        run_op("post_rst_9_3", 32'd9, 32'd3, 0, 1'b0, 1'b0);

        // Randomized operands, handshake order, gaps and BUSY-time noise.
        for (int k = 0; k < 24; k++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                default: b = $urandom & 32'hFF;
            endcase
            run_op($sformatf("rnd%0d", k), a, b, $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
